// File: rtl/cpu_status_uart_tx.sv
// Streams every change of the CPU result bus and flags to a host as a pair of 8N1 frames:
// byte 0 = result, byte 1 = {4'hA, C, Z, V, N}. Records are buffered in a small FIFO.
module cpu_status_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        out_i,
  input  logic [3:0]        flags_i,
  input  logic              capture_en_i,
  output logic              tx_o,
  output logic              busy_o,
  output logic              overflow_o,
  output logic [ADDR_W:0]   fifo_level_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0]   LEVEL_FULL = (ADDR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  logic [11:0]       sample_s;
  logic [11:0]       last_q;
  logic [11:0]       fifo_mem_q [FIFO_DEPTH];
  logic [11:0]       head_s;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   level_q;
  logic [ADDR_W:0]   level_d;
  logic              overflow_q;
  logic              change_s;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic [2:0]        bit_q, bit_d;
  logic [2:0]        bit_nxt_s;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic              baud_wrap_s;
  logic [11:0]       shift_q, shift_d;
  logic [7:0]        byte_s;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  assign sample_s = {out_i, flags_i};
  assign change_s = (sample_s != last_q) && capture_en_i;
  // Fullness is judged before this edge's pop, so a push into a full FIFO is lost even if a pop frees a slot.
  assign full_s   = (level_q == LEVEL_FULL);
  assign empty_s  = (level_q == {(ADDR_W+1){1'b0}});
  assign push_s   = change_s && !full_s;
  assign head_s   = fifo_mem_q[rd_ptr_q];

  // FIFO occupancy next-state
  always_comb begin
    level_d = level_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + (ADDR_W+1)'(1);
      2'b01:   level_d = level_q - (ADDR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Change-detect register, FIFO pointers, level and sticky overflow
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q     <= 12'h000;
      wr_ptr_q   <= {ADDR_W{1'b0}};
      rd_ptr_q   <= {ADDR_W{1'b0}};
      level_q    <= {(ADDR_W+1){1'b0}};
      overflow_q <= 1'b0;
    end else begin
      last_q  <= sample_s;
      level_q <= level_d;
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
      if (change_s && full_s) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Record storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= sample_s;
    end
  end

  assign byte_s      = sel_q ? {4'hA, shift_q[3:0]} : shift_q[11:4];
  assign bit_nxt_s   = bit_q + 3'd1;
  assign baud_wrap_s = (baud_q == BAUD_LAST);

  // Transmit FSM next-state; tx/busy are computed one cycle ahead and registered
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop_s   = 1'b0;
    baud_d  = baud_wrap_s ? {BAUD_W{1'b0}} : baud_q + BAUD_W'(1);
    case (state_q)
      ST_IDLE: begin
        baud_d = {BAUD_W{1'b0}};
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!empty_s) begin
          pop_s   = 1'b1;
          shift_d = head_s;
          sel_d   = 1'b0;
          state_d = ST_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_wrap_s) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          tx_d    = byte_s[0];
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (baud_wrap_s) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nxt_s;
            tx_d  = byte_s[bit_nxt_s];
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (baud_wrap_s) begin
          if (!sel_q) begin
            sel_d   = 1'b1;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else if (!empty_s) begin
            pop_s   = 1'b1;
            shift_d = head_s;
            sel_d   = 1'b0;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Transmit FSM state and registered line outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      bit_q   <= 3'd0;
      baud_q  <= {BAUD_W{1'b0}};
      shift_q <= 12'h000;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign overflow_o   = overflow_q;
  assign fifo_level_o = level_q;

endmodule

// File: tb/tb_cpu_status_uart_tx.sv
// Directed bench for cpu_status_uart_tx: a UART monitor decodes tx_o into 10-bit frames
// which are compared against hand-computed records.
module tb_cpu_status_uart_tx;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] out_i = 8'h00;
  logic [3:0] flags_i = 4'h0;
  logic       capture_en_i = 1'b1;
  logic       tx_o;
  logic       busy_o;
  logic       overflow_o;
  logic [2:0] fifo_level_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [9:0] rx_q[$];
  int         start_q[$];

  cpu_status_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .ADDR_W(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .out_i        (out_i),
    .flags_i      (flags_i),
    .capture_en_i (capture_en_i),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .overflow_o   (overflow_o),
    .fifo_level_o (fifo_level_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // UART receiver: frame start seen at the falling edge, bits sampled mid-bit
  initial begin
    logic       prev_tx;
    logic [9:0] fr;
    int         sc;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk_i);
      if (!rst_i && tx_o == 1'b0 && prev_tx == 1'b1) begin
        sc = cyc;
        repeat (2) @(negedge clk_i);
        fr[0] = tx_o;
        for (int k = 1; k < 10; k++) begin
          repeat (4) @(negedge clk_i);
          fr[k] = tx_o;
        end
        rx_q.push_back(fr);
        start_q.push_back(sc);
        prev_tx = fr[9];
      end else begin
        prev_tx = tx_o;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_pair(input string tag, input logic [7:0] b0, input logic [7:0] b1);
    if (rx_q.size() < 2) begin
      check_eq({tag, "_frames"}, rx_q.size(), 2);
    end else begin
      check_eq({tag, "_b0"}, rx_q.pop_front(), {1'b1, b0, 1'b0});
      check_eq({tag, "_b1"}, rx_q.pop_front(), {1'b1, b1, 1'b0});
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    repeat (3) @(negedge clk_i);
    while ((busy_o || fifo_level_o != 3'd0) && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    check_eq({tag, "_idle"}, (n < 2000), 1);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    start_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    check_eq("rst_tx", tx_o, 1);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_ovf", overflow_o, 0);
    check_eq("rst_level", fifo_level_o, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // single change: push at edge 1, start bit from edge 2, pair done at edge 82
    out_i = 8'h5A; flags_i = 4'h3;
    @(negedge clk_i);
    check_eq("t1_level_e1", fifo_level_o, 1);
    check_eq("t1_tx_e1", tx_o, 1);
    @(negedge clk_i);
    check_eq("t1_tx_e2", tx_o, 0);
    check_eq("t1_busy_e2", busy_o, 1);
    check_eq("t1_level_e2", fifo_level_o, 0);
    repeat (79) @(negedge clk_i);
    check_eq("t1_busy_e81", busy_o, 1);
    @(negedge clk_i);
    check_eq("t1_busy_e82", busy_o, 0);
    check_eq("t1_level_e82", fifo_level_o, 0);
    check_eq("t1_tx_e82", tx_o, 1);
    check_eq("t1_nframes", rx_q.size(), 2);
    expect_pair("t1", 8'h5A, 8'hA3);

    // burst of six: fifth fills the FIFO, sixth is dropped
    clear_rx();
    out_i = 8'h01; flags_i = 4'h0;
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk_i);
      if (i == 6) begin
        check_eq("t2_ovf_e5", overflow_o, 0);
        check_eq("t2_level_e5", fifo_level_o, 4);
      end
      out_i = 8'(i);
    end
    @(negedge clk_i);
    check_eq("t2_ovf_e6", overflow_o, 1);
    check_eq("t2_level_e6", fifo_level_o, 4);
    wait_idle("t2");
    check_eq("t2_ovf_sticky", overflow_o, 1);
    check_eq("t2_nframes", rx_q.size(), 10);
    if (start_q.size() == 10) begin
      check_eq("t2_b2b_span", start_q[9] - start_q[0], 360);
    end
    for (int k = 1; k <= 5; k++) begin
      expect_pair("t2_rec", 8'(k), 8'hA0);
    end

    // enable gating: changes while disabled never produce a record
    clear_rx();
    capture_en_i = 1'b0;
    out_i = 8'h11;
    @(negedge clk_i);
    out_i = 8'h22;
    @(negedge clk_i);
    capture_en_i = 1'b1;
    repeat (10) @(negedge clk_i);
    check_eq("t3_level", fifo_level_o, 0);
    check_eq("t3_busy", busy_o, 0);
    check_eq("t3_nframes_gated", rx_q.size(), 0);
    out_i = 8'h33;
    wait_idle("t3");
    check_eq("t3_nframes", rx_q.size(), 2);
    expect_pair("t3", 8'h33, 8'hA0);

    // reset during bit 3 of byte 0 (0xC4 bit 3 is 0)
    clear_rx();
    out_i = 8'hC4;
    repeat (19) @(negedge clk_i);
    check_eq("t5_tx_bit3", tx_o, 0);
    check_eq("t5_busy_pre", busy_o, 1);
    rst_i = 1'b1;
    capture_en_i = 1'b0;
    #1;
    check_eq("t5_tx_rst", tx_o, 1);
    check_eq("t5_level_rst", fifo_level_o, 0);
    check_eq("t5_busy_rst", busy_o, 0);
    check_eq("t5_ovf_rst", overflow_o, 0);
    repeat (25) @(negedge clk_i);
    clear_rx();
    rst_i = 1'b0;
    @(negedge clk_i);
    capture_en_i = 1'b1;
    repeat (100) @(negedge clk_i);
    check_eq("t5_nframes", rx_q.size(), 0);
    check_eq("t5_busy", busy_o, 0);
    check_eq("t5_tx", tx_o, 1);

    // full FIFO while byte-1 STOP of record 1 ends on the same edge as a push
    clear_rx();
    out_i = 8'h10;
    for (int i = 2; i <= 5; i++) begin
      @(negedge clk_i);
      out_i = 8'h10 + 8'(i - 1);
    end
    @(negedge clk_i);
    check_eq("t4_level_full", fifo_level_o, 4);
    repeat (76) @(negedge clk_i);
    check_eq("t4_level_e81", fifo_level_o, 4);
    check_eq("t4_ovf_e81", overflow_o, 0);
    out_i = 8'h20;
    @(negedge clk_i);
    check_eq("t4_level_e82", fifo_level_o, 3);
    check_eq("t4_ovf_e82", overflow_o, 1);
    wait_idle("t4");
    check_eq("t4_nframes", rx_q.size(), 10);
    for (int k = 0; k < 5; k++) begin
      expect_pair("t4_rec", 8'h10 + 8'(k), 8'hA0);
    end

    // flag-only changes; first step changes out and flags together
    clear_rx();
    out_i = 8'h7F; flags_i = 4'h1;
    wait_idle("t6a");
    check_eq("t6a_nframes", rx_q.size(), 2);
    expect_pair("t6a", 8'h7F, 8'hA1);
    flags_i = 4'h0;
    wait_idle("t6b");
    check_eq("t6b_nframes", rx_q.size(), 2);
    expect_pair("t6b", 8'h7F, 8'hA0);
    flags_i = 4'h1;
    wait_idle("t6c");
    check_eq("t6c_nframes", rx_q.size(), 2);
    expect_pair("t6c", 8'h7F, 8'hA1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
